// File: rtl/lvds_pkg.sv
// Shared types and constants for the two-source LVDS frame arbiter.
package lvds_pkg;

  localparam int unsigned NumSrc = 2;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StDrain
  } state_e;

  function automatic int unsigned frame_words(input int unsigned frame_num,
                                              input int unsigned data_width);
    return frame_num / (data_width / 8);
  endfunction

endpackage

// File: rtl/lvds_skid_buf.sv
// Two-entry output buffer; an empty buffer passes the incoming word straight through
// so a read issued in one cycle is presentable in the next.
module lvds_skid_buf #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    valid_o = (count_q != 2'd0) || push_i;
    data_o  = (count_q != 2'd0) ? mem0_q : data_i;
    count_o = count_q;
    case (count_q)
      2'd0: begin
        if (push_i && !pop_i) begin
          mem0_d  = data_i;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (pop_i && push_i) begin
          mem0_d = data_i;
        end else if (pop_i) begin
          count_d = 2'd0;
        end else if (push_i) begin
          mem1_d  = data_i;
          count_d = 2'd2;
        end
      end
      default: begin
        if (pop_i) begin
          mem0_d = mem1_q;
          if (push_i) begin
            mem1_d = data_i;
          end else begin
            count_d = 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lvds_frame_arb.sv
// Round-robin arbiter moving whole frames from two source FIFOs onto one AXI-Stream master.
module lvds_frame_arb
  import lvds_pkg::*;
#(
  parameter int unsigned M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned FRAME_NUM          = 1024,
  parameter int unsigned CNT_W              = 11
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [CNT_W-1:0]                src_rd_data_cnt_0,
  input  logic [CNT_W-1:0]                src_rd_data_cnt_1,
  input  logic [M_AXIS_TDATA_WIDTH-1:0]   src_dout_0,
  input  logic [M_AXIS_TDATA_WIDTH-1:0]   src_dout_1,
  output logic                            src_rd_en_0,
  output logic                            src_rd_en_1,
  input  logic                            M_AXIS_TREADY,
  output logic                            M_AXIS_TVALID,
  output logic [M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic                            M_AXIS_TLAST,
  output logic [M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                            M_AXIS_TUSER,
  output logic [15:0]                     frame_cnt_0,
  output logic [15:0]                     frame_cnt_1,
  output logic                            busy
);

  localparam int unsigned FrameWords = frame_words(FRAME_NUM, M_AXIS_TDATA_WIDTH);
  localparam int unsigned IdxW       = $clog2(FrameWords + 1);

  state_e                        state_q, state_d;
  logic                          grant_q, grant_d;
  logic                          inflight_q;
  logic [IdxW-1:0]               issued_q, issued_d;
  logic [IdxW-1:0]               beat_q, beat_d;
  logic [NumSrc-1:0][15:0]       frame_cnt_q, frame_cnt_d;

  logic [NumSrc-1:0]             elig;
  logic                          rd_en, pop, tlast;
  logic                          buf_valid;
  logic [M_AXIS_TDATA_WIDTH-1:0] buf_data, push_data;
  logic [1:0]                    buf_count;
  logic [2:0]                    occ;

  assign push_data = grant_q ? src_dout_1 : src_dout_0;

  lvds_skid_buf #(
    .Width (M_AXIS_TDATA_WIDTH)
  ) u_skid_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .data_i  (push_data),
    .pop_i   (pop),
    .valid_o (buf_valid),
    .data_o  (buf_data),
    .count_o (buf_count)
  );

  always_comb begin
    elig[0]     = enable && (src_rd_data_cnt_0 >= CNT_W'(FrameWords));
    elig[1]     = enable && (src_rd_data_cnt_1 >= CNT_W'(FrameWords));
    pop         = buf_valid && M_AXIS_TREADY;
    tlast       = (beat_q == IdxW'(FrameWords - 1));
    // Words held or arriving next cycle once this cycle's pop retires.
    occ         = {1'b0, buf_count} + {2'b00, inflight_q};
    state_d     = state_q;
    grant_d     = grant_q;
    issued_d    = issued_q;
    beat_d      = beat_q;
    frame_cnt_d = frame_cnt_q;
    rd_en       = 1'b0;
    case (state_q)
      StIdle: begin
        issued_d = '0;
        beat_d   = '0;
        if (elig != '0) begin
          grant_d = (elig[0] && elig[1]) ? ~grant_q : elig[1];
          state_d = StSend;
        end
      end
      StSend: begin
        if ((issued_q < IdxW'(FrameWords)) && (occ < (3'd2 + {2'b00, pop}))) begin
          rd_en    = 1'b1;
          issued_d = issued_q + IdxW'(1);
        end
        if (issued_d == IdxW'(FrameWords)) begin
          state_d = StDrain;
        end
        if (pop) begin
          beat_d = beat_q + IdxW'(1);
        end
      end
      StDrain: begin
        if (pop) begin
          beat_d = beat_q + IdxW'(1);
          if (tlast) begin
            state_d              = StIdle;
            frame_cnt_d[grant_q] = frame_cnt_q[grant_q] + 16'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= 1'b1;
      inflight_q  <= 1'b0;
      issued_q    <= '0;
      beat_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      inflight_q  <= rd_en;
      issued_q    <= issued_d;
      beat_q      <= beat_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    src_rd_en_0   = !rst && rd_en && !grant_q;
    src_rd_en_1   = !rst && rd_en && grant_q;
    M_AXIS_TVALID = !rst && buf_valid;
    M_AXIS_TDATA  = (!rst && buf_valid) ? buf_data : '0;
    M_AXIS_TLAST  = !rst && buf_valid && tlast;
    M_AXIS_TUSER  = !rst && buf_valid && grant_q;
    M_AXIS_TSTRB  = '1;
    frame_cnt_0   = rst ? 16'd0 : frame_cnt_q[0];
    frame_cnt_1   = rst ? 16'd0 : frame_cnt_q[1];
    busy          = !rst && (state_q != StIdle);
  end

endmodule

// File: tb/tb_lvds_frame_arb.sv
// Directed bench for lvds_frame_arb with two behavioural source FIFOs.
module tb_lvds_frame_arb;

  localparam int unsigned W        = 32;
  localparam int unsigned FrameNum = 1024;
  localparam int unsigned CntW     = 11;
  localparam int          FW       = 256;

  logic            clk = 1'b0;
  logic            rst, enable, m_tready;
  logic [CntW-1:0] cnt0, cnt1;
  logic [W-1:0]    dout0, dout1;
  logic            rd0, rd1;
  logic            tvalid, tlast, tuser, busy;
  logic [W-1:0]    tdata;
  logic [W/8-1:0]  tstrb;
  logic [15:0]     fc0, fc1;

  int wr_total0 = 0, wr_total1 = 0;
  int rd_total0 = 0, rd_total1 = 0;
  int checks = 0, failures = 0;
  int exp_ptr0 = 0, exp_ptr1 = 0;
  int r_beats, r_src, r_errs, r_stall_errs, r_max_out, r_span;
  bit r_last_ok;
  int seen;

  always #5 clk = ~clk;

  lvds_frame_arb #(
    .M_AXIS_TDATA_WIDTH (W),
    .FRAME_NUM          (FrameNum),
    .CNT_W              (CntW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .src_rd_data_cnt_0 (cnt0),
    .src_rd_data_cnt_1 (cnt1),
    .src_dout_0        (dout0),
    .src_dout_1        (dout1),
    .src_rd_en_0       (rd0),
    .src_rd_en_1       (rd1),
    .M_AXIS_TREADY     (m_tready),
    .M_AXIS_TVALID     (tvalid),
    .M_AXIS_TDATA      (tdata),
    .M_AXIS_TLAST      (tlast),
    .M_AXIS_TSTRB      (tstrb),
    .M_AXIS_TUSER      (tuser),
    .frame_cnt_0       (fc0),
    .frame_cnt_1       (fc1),
    .busy              (busy)
  );

  function automatic logic [W-1:0] pat(input bit s, input int n);
    return {s ? 4'hB : 4'hA, n[27:0]};
  endfunction

  assign cnt0 = (wr_total0 > rd_total0) ? CntW'(wr_total0 - rd_total0) : '0;
  assign cnt1 = (wr_total1 > rd_total1) ? CntW'(wr_total1 - rd_total1) : '0;

  // Source FIFOs: one-cycle read latency, word pattern tags source and position.
  always @(posedge clk) begin
    if (rd0) begin
      dout0     <= pat(1'b0, rd_total0);
      rd_total0 <= rd_total0 + 1;
    end
    if (rd1) begin
      dout1     <= pat(1'b1, rd_total1);
      rd_total1 <= rd_total1 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: TREADY high; mode 1: random TREADY with a 200-cycle stall after beat 100.
  task automatic recv_frame(input int mode, input int budget, input int drop_en_at,
                            input int rst_at);
    int base, acc, stall, first_c;
    bit stall_first, stalling;
    logic [W-1:0] held, exp;
    r_beats = 0; r_src = -1; r_errs = 0; r_stall_errs = 0; r_max_out = 0; r_span = -1;
    r_last_ok = 1'b0;
    base = rd_total0 + rd_total1; acc = 0; stall = 0; first_c = 0;
    stall_first = 1'b0; held = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      stalling = 1'b0;
      if (stall > 0) begin
        m_tready = 1'b0;
        stall--;
        stalling = 1'b1;
      end else if (mode == 1) begin
        m_tready = 1'($urandom_range(0, 1));
      end else begin
        m_tready = 1'b1;
      end
      #1;
      if (rd_total0 + rd_total1 - base - acc > r_max_out)
        r_max_out = rd_total0 + rd_total1 - base - acc;
      if (stalling) begin
        if (!stall_first) begin
          held = tdata;
          stall_first = 1'b1;
        end else if (tdata !== held || tvalid !== 1'b1) begin
          r_stall_errs++;
        end
      end
      if (tvalid && m_tready) begin
        if (r_beats == 0) begin
          r_src = int'(tuser);
          first_c = c;
        end
        exp = tuser ? pat(1'b1, exp_ptr1) : pat(1'b0, exp_ptr0);
        if (tuser) exp_ptr1++; else exp_ptr0++;
        if (tdata !== exp || int'(tuser) != r_src) r_errs++;
        acc++;
        r_beats++;
        if (tlast) begin
          r_last_ok = (r_beats == FW);
          r_span = c - first_c;
          return;
        end
        if (mode == 1 && r_beats == 100) stall = 200;
        if (r_beats == drop_en_at) enable = 1'b0;
        if (r_beats == rst_at) begin
          rst = 1'b1;
          return;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; m_tready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tstrb", tstrb, 4'hF);
    chk("rst_rd_en", {rd0, rd1}, 0);
    chk("rst_busy", busy, 0);

    // Count one short of a frame must never be granted.
    @(negedge clk);
    rst = 1'b0; enable = 1'b1; m_tready = 1'b1; wr_total0 = 255;
    seen = 0;
    repeat (1000) begin
      @(negedge clk); #1;
      if (rd0 || rd1 || tvalid || busy) seen++;
    end
    chk("cnt255_idle", seen, 0);
    chk("cnt255_fc0", fc0, 0);

    @(negedge clk);
    m_tready = 1'b0; wr_total0 = 256;
    #1;
    chk("lat_n_busy", busy, 0);
    @(negedge clk); #1;
    chk("lat_n1_rd_en", {rd0, rd1}, 2'b10);
    chk("lat_n1_tvalid", tvalid, 0);
    chk("lat_n1_busy", busy, 1);
    @(negedge clk); #1;
    chk("lat_n2_tvalid", tvalid, 1);
    chk("lat_n2_tdata", tdata, pat(1'b0, 0));
    chk("lat_n2_tuser", tuser, 0);
    recv_frame(0, 2000, -1, -1);
    chk("f1_beats", r_beats, FW);
    chk("f1_last", r_last_ok, 1);
    chk("f1_src", r_src, 0);
    chk("f1_data", r_errs, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("f1_fc0", fc0, 1);
    chk("f1_busy_after", busy, 0);

    // Full-rate frame.
    wr_total0 += 256;
    recv_frame(0, 2000, -1, -1);
    chk("tput_beats", r_beats, FW);
    chk("tput_span", r_span, FW - 1);
    chk("tput_last", r_last_ok, 1);
    chk("tput_data", r_errs, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("tput_fc0", fc0, 2);

    // Both sources loaded after a reset: strict alternation starting at source 0.
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rr_fc0_cleared", fc0, 0);
    wr_total0 += 512; wr_total1 += 512;
    for (int f = 0; f < 4; f++) begin
      recv_frame(0, 2000, -1, -1);
      chk("rr_src", r_src, f % 2);
      chk("rr_beats", r_beats, FW);
      chk("rr_data", r_errs, 0);
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rr_fc0", fc0, 2);
    chk("rr_fc1", fc1, 2);

    // Random backpressure with a long stall.
    wr_total0 += 256;
    recv_frame(1, 6000, -1, -1);
    chk("bp_beats", r_beats, FW);
    chk("bp_last", r_last_ok, 1);
    chk("bp_data", r_errs, 0);
    chk("bp_stall_stable", r_stall_errs, 0);
    chk("bp_outstanding_le2", (r_max_out <= 2), 1);

    // Enable dropped mid-frame: frame completes, no new grant.
    wr_total0 += 512;
    recv_frame(0, 2000, 10, -1);
    chk("en_drop_beats", r_beats, FW);
    chk("en_drop_last", r_last_ok, 1);
    seen = 0;
    repeat (100) begin
      @(negedge clk); #1;
      if (rd0 || rd1 || tvalid || busy) seen++;
    end
    chk("en_drop_no_grant", seen, 0);
    chk("en_drop_fc0", fc0, 4);

    // Reset mid-frame.
    @(negedge clk);
    enable = 1'b1;
    recv_frame(0, 2000, -1, 50);
    chk("rst_mid_beats", r_beats, 50);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_tvalid", tvalid, 0);
    chk("rst_mid_tlast", tlast, 0);
    chk("rst_mid_rd_en", {rd0, rd1}, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_fc0", fc0, 0);
    exp_ptr0 = rd_total0;
    wr_total0 += 256; wr_total1 += 256;
    recv_frame(0, 2000, -1, -1);
    chk("post_rst_src", r_src, 0);
    chk("post_rst_beats", r_beats, FW);
    chk("post_rst_last", r_last_ok, 1);
    chk("post_rst_data", r_errs, 0);
    recv_frame(0, 2000, -1, -1);
    chk("post_rst_src1", r_src, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("post_rst_fc0", fc0, 1);
    chk("post_rst_fc1", fc1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lvds_frame_arb.md
LVDS_FRAME_ARB -- requirements
Module: lvds_frame_arb

Interface
REQ-001 The block SHALL have parameter M_AXIS_TDATA_WIDTH, default 32, giving the stream and source data width in bits.
REQ-002 The block SHALL have parameter FRAME_NUM, default 1024, giving the frame length in bytes; FRAME_WORDS = FRAME_NUM/(M_AXIS_TDATA_WIDTH/8), which is 256 at the defaults.
REQ-003 The block SHALL have parameter CNT_W, default 11, giving the source FIFO read-count width.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports:
- clk  in  1  sole clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
REQ-005 The block SHALL have the following ports (index i = 0,1 selects the source FIFO):
- enable  in  1  permits new frame grants
- src_rd_data_cnt_i  in  CNT_W  read-side word count of source FIFO i
- src_dout_i  in  M_AXIS_TDATA_WIDTH  read data of FIFO i, valid 1 cycle after src_rd_en_i
- src_rd_en_i  out  1  read strobe to FIFO i
- M_AXIS_TREADY  in  1  downstream DMA ready
- M_AXIS_TVALID  out  1  stream valid
- M_AXIS_TDATA  out  M_AXIS_TDATA_WIDTH  stream data
- M_AXIS_TLAST  out  1  last beat of a frame
- M_AXIS_TSTRB  out  M_AXIS_TDATA_WIDTH/8  byte strobes, always all ones
- M_AXIS_TUSER  out  1  index of the source FIFO owning the current beat
- frame_cnt_i  out  16  completed frames from source i; wraps at 2^16
- busy  out  1  high when state is not IDLE

Function
REQ-006 The state machine SHALL have states IDLE, SEND and DRAIN.
REQ-007 Source i SHALL be eligible when enable=1 and src_rd_data_cnt_i >= FRAME_WORDS; a count of FRAME_WORDS-1 SHALL not be eligible.
REQ-008 In IDLE, if any source is eligible, the block SHALL register the grant and enter SEND on the next cycle.
REQ-009 When both sources are eligible, the grant SHALL go to the source not granted last; after reset, source 0 wins.
REQ-010 When only one source is eligible, it SHALL be granted, including back-to-back after its own frame.
REQ-011 In SEND, src_rd_en of the granted source SHALL be asserted only when:
- issued < FRAME_WORDS, and
- (buffered words + reads in flight - pop this cycle) < 2.
The other source's src_rd_en SHALL stay 0.
REQ-012 Read data SHALL enter a 2-entry output buffer exactly 1 cycle after each src_rd_en.
REQ-013 With TREADY held high, the block SHALL sustain 1 beat per cycle.
REQ-014 A pop SHALL occur on each cycle with TVALID=1 and TREADY=1.
REQ-015 While TVALID=1 and TREADY=0, TDATA, TLAST and TUSER SHALL hold stable.
REQ-016 Beats SHALL be counted per frame; TLAST SHALL be 1 only on beat number FRAME_WORDS.
REQ-017 When issued reaches FRAME_WORDS, the state SHALL go SEND->DRAIN.
REQ-018 On the handshake of the TLAST beat, the block SHALL go DRAIN->IDLE and increment frame_cnt of the granted source by 1.
REQ-019 A fresh arbitration SHALL take place in IDLE, so there is at least 1 idle cycle between frames.
REQ-020 Deasserting enable mid-frame SHALL NOT truncate the frame; the current frame completes, and no new grant is made.
REQ-021 Changes in src_rd_data_cnt after a grant SHALL be ignored; the frame is committed.
REQ-022 First-beat latency SHALL be:
- grant registered in cycle N,
- first src_rd_en in cycle N+1,
- TVALID in cycle N+2.

Reset
REQ-023 While rst=1, all outputs SHALL be 0 except M_AXIS_TSTRB, which stays all ones.
REQ-024 Reset SHALL clear: state to IDLE, the buffer, all counters and the round-robin pointer (which points so that source 0 wins next).
REQ-025 Reset asserted mid-frame SHALL drop the partial frame with no TLAST; src_rd_en SHALL be 0 in the cycle after rst is sampled high.

Structure
REQ-026 Package lvds_pkg SHALL hold the state enumeration, the FRAME_WORDS derivation and the source-count constant (2).
REQ-027 The 2-entry output buffer SHALL be a sub-module, lvds_skid_buf, with push/pop/count ports.

Verification
REQ-028 Single source, TREADY=1: src_rd_data_cnt_0=256 -> 256 beats on consecutive cycles, TLAST on beat 256, TUSER=0, frame_cnt_0=1, busy low afterwards.
REQ-029 Boundary count: src_rd_data_cnt_0=255 held for 1000 cycles -> no src_rd_en and TVALID=0; stepping to 256 -> grant follows.
REQ-030 Both sources at 512 words -> frames in the order 0,1,0,1, each exactly 256 beats, with frame_cnt_0=frame_cnt_1=2.
REQ-031 TREADY toggling randomly at 50%, plus a 200-cycle stall at beat 100 -> data order matches FIFO order, TDATA stable during the stall, never more than 2 outstanding reads.
REQ-032 enable dropped at beat 10 -> the frame completes all 256 beats with TLAST, then no further grant even with cnt=512.
REQ-033 rst pulsed at beat 50 -> all outputs 0 on the next cycle, no TLAST; after release, the next frame starts with source 0 and is 256 beats long.
